// File: rtl/preamble_1010_tx.sv
// rtl/preamble_1010_tx.sv - serial frame transmitter: preamble 1010, MSB-first payload, optional even parity
module preamble_1010_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              frame_start
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_PAR} state_t;

  // state_q names the frame segment whose bit is on out_q this cycle
  state_t            state_q, state_d;
  logic [1:0]        pre_idx_q, pre_idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic              fs_q, fs_d;
  logic              last_bit;
  logic              accept;

  assign last_bit = (state_q == S_PAR) ||
                    ((state_q == S_DATA) && (cnt_q == LAST_CNT) && (PARITY_EN == 0));
  assign in_ready = (state_q == S_IDLE) || last_bit;
  assign accept   = in_valid && in_ready;

  assign out         = out_q;
  assign out_valid   = valid_q;
  assign frame_start = fs_q;

  always_comb begin
    state_d   = state_q;
    pre_idx_d = pre_idx_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    fs_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
      end
      S_PRE: begin
        valid_d = 1'b1;
        if (pre_idx_q == 2'd3) begin
          state_d = S_DATA;
          out_d   = shreg_q[DATA_W-1];
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = CW'(1);
        end else begin
          // preamble bit at index n is ~n[0]; next index is pre_idx_q+1
          pre_idx_d = pre_idx_q + 2'd1;
          out_d     = pre_idx_q[0];
        end
      end
      S_DATA: begin
        if (cnt_q != LAST_CNT) begin
          valid_d = 1'b1;
          out_d   = shreg_q[DATA_W-1];
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end else if (PARITY_EN != 0) begin
          state_d = S_PAR;
          valid_d = 1'b1;
          out_d   = par_q;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_PAR: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // accept only happens in IDLE or on a final bit, so it always starts a new frame
    if (accept) begin
      state_d   = S_PRE;
      pre_idx_d = 2'd0;
      cnt_d     = '0;
      shreg_d   = in_data;
      par_d     = ^in_data;
      out_d     = 1'b1;
      valid_d   = 1'b1;
      fs_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      pre_idx_q <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_idx_q <= pre_idx_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      fs_q      <= fs_d;
    end
  end

endmodule

// File: tb/tb_preamble_1010_tx.sv
// tb/tb_preamble_1010_tx.sv - self-checking bench for preamble_1010_tx with a frame-queue model
module tb_preamble_1010_tx;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       v8 = 1'b0;
  logic [7:0] d8 = '0;
  logic       rdy8, o8, ov8, fs8;
  logic       v4 = 1'b0;
  logic [3:0] d4 = '0;
  logic       rdy4, o4, ov4, fs4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  preamble_1010_tx #(.DATA_W(8), .PARITY_EN(1)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
    .out(o8), .out_valid(ov8), .frame_start(fs8)
  );

  preamble_1010_tx #(.DATA_W(4), .PARITY_EN(0)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out(o4), .out_valid(ov4), .frame_start(fs4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // whole frame as a right-aligned bit vector, first-sent bit most significant
  function automatic logic [39:0] mkframe(input logic [31:0] d, input int w, input int p);
    logic [39:0] f;
    logic        par;
    f   = 40'b1010;
    par = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      f   = {f[38:0], d[i]};
      par = par ^ d[i];
    end
    if (p != 0) f = {f[38:0], par};
    return f;
  endfunction

  // queue holds the bits still owed for the current frame; head is the bit on the wire now
  bit          q8[$];
  bit          s8[$];
  bit          q4[$];
  bit          s4[$];
  bit          acc8 = 1'b0;
  bit          acc4 = 1'b0;
  int          cyc = 0;
  logic [39:0] f8, f4;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q8.delete(); s8.delete(); q4.delete(); s4.delete();
      acc8 = 1'b0;
      acc4 = 1'b0;
    end else begin
      cyc++;
      acc8 = v8 && (q8.size() <= 1);
      acc4 = v4 && (q4.size() <= 1);
      if (q8.size() > 0) begin q8.delete(0); s8.delete(0); end
      if (q4.size() > 0) begin q4.delete(0); s4.delete(0); end
      if (acc8) begin
        f8 = mkframe({24'b0, d8}, 8, 1);
        for (int i = 12; i >= 0; i--) begin q8.push_back(f8[i]); s8.push_back(i == 12); end
      end
      if (acc4) begin
        f4 = mkframe({28'b0, d4}, 4, 0);
        for (int i = 7; i >= 0; i--) begin q4.push_back(f4[i]); s4.push_back(i == 7); end
      end
    end
  end

  always @(negedge clk) begin
    chk("out8",   64'(o8),   (q8.size() > 0) ? 64'(q8[0]) : 64'd0);
    chk("valid8", 64'(ov8),  64'(q8.size() > 0));
    chk("fs8",    64'(fs8),  (q8.size() > 0) ? 64'(s8[0]) : 64'd0);
    chk("ready8", 64'(rdy8), 64'(q8.size() <= 1));
    chk("out4",   64'(o4),   (q4.size() > 0) ? 64'(q4[0]) : 64'd0);
    chk("valid4", 64'(ov4),  64'(q4.size() > 0));
    chk("fs4",    64'(fs4),  (q4.size() > 0) ? 64'(s4[0]) : 64'd0);
    chk("ready4", 64'(rdy4), 64'(q4.size() <= 1));
  end

  logic [63:0] rec8, rdyrec8, rec4, rdyrec4;
  int          rec8_n, rec4_n, fsn8;
  logic [3:0]  det_sh;
  int          det_n;

  always @(negedge clk) begin
    if (ov8) begin
      rec8    = {rec8[62:0], o8};
      rdyrec8 = {rdyrec8[62:0], rdy8};
      rec8_n++;
      if (fs8) fsn8++;
      det_sh = {det_sh[2:0], o8};
      if (det_sh == 4'b1010) det_n++;
    end
    if (ov4) begin
      rec4    = {rec4[62:0], o4};
      rdyrec4 = {rdyrec4[62:0], rdy4};
      rec4_n++;
    end
  end

  task automatic clear_rec();
    rec8 = '0; rdyrec8 = '0; rec8_n = 0; fsn8 = 0;
    rec4 = '0; rdyrec4 = '0; rec4_n = 0;
    det_sh = '0; det_n = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d);
    int n;
    v8 = 1'b1;
    d8 = d;
    n  = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc8 && n < 200);
    if (!acc8) chk("accept8_timeout", 64'd0, 64'd1);
  endtask

  task automatic send4(input logic [3:0] d);
    int n;
    v4 = 1'b1;
    d4 = d;
    n  = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc4 && n < 200);
    if (!acc4) chk("accept4_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() > 0 || q4.size() > 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
    step(1);
  endtask

  int t0;

  initial begin
    clear_rec();
    #2;
    chk("reset_ready8", 64'(rdy8), 64'd1);
    chk("reset_out8",   64'(o8),   64'd0);
    chk("reset_valid8", 64'(ov8),  64'd0);
    chk("reset_fs8",    64'(fs8),  64'd0);
    chk("reset_ready4", 64'(rdy4), 64'd1);
    #10 rstn = 1'b1;
    step(2);

    clear_rec();
    send8(8'hA5);
    v8 = 1'b0;
    drain();
    chk("a5_stream", rec8[12:0], 64'(13'b1010_10100101_0));
    chk("a5_len", 64'(rec8_n), 64'd13);
    chk("a5_fs_count", 64'(fsn8), 64'd1);
    chk("a5_ready_map", rdyrec8[12:0], 64'(13'b0000000000001));

    clear_rec();
    send8(8'h01);
    t0 = cyc;
    send8(8'h80);
    chk("b2b_accept_gap", 64'(cyc - t0), 64'd13);
    v8 = 1'b0;
    drain();
    chk("b2b_stream", rec8[25:0], 64'(26'b1010_00000001_1_1010_10000000_1));
    chk("b2b_len", 64'(rec8_n), 64'd26);
    chk("b2b_fs_count", 64'(fsn8), 64'd2);

    clear_rec();
    send4(4'hF);
    v4 = 1'b0;
    drain();
    chk("w4_stream", rec4[7:0], 64'(8'b1010_1111));
    chk("w4_len", 64'(rec4_n), 64'd8);
    chk("w4_ready_map", rdyrec4[7:0], 64'(8'b00000001));

    clear_rec();
    send8(8'hA5);
    v8 = 1'b0;
    step(6);
    chk("pre_reset_bit", 64'(o8), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("abort_out",   64'(o8),   64'd0);
    chk("abort_valid", 64'(ov8),  64'd0);
    chk("abort_fs",    64'(fs8),  64'd0);
    chk("abort_ready", 64'(rdy8), 64'd1);
    step(2);
    rstn = 1'b1;
    step(1);
    clear_rec();
    send8(8'h3C);
    v8 = 1'b0;
    drain();
    chk("post_reset_stream", rec8[12:0], 64'(13'b1010_00111100_0));
    chk("post_reset_len", 64'(rec8_n), 64'd13);

    clear_rec();
    send8(8'hA5);
    t0 = cyc;
    v8 = 1'b0;
    step(4);
    send8(8'hFF);
    chk("busy_accept_edge", 64'(cyc - t0), 64'd13);
    v8 = 1'b0;
    drain();
    chk("busy_stream", rec8[25:0], 64'({13'b1010_10100101_0, 13'b1010_11111111_0}));
    chk("busy_len", 64'(rec8_n), 64'd26);

    clear_rec();
    send8(8'h00);
    send8(8'h00);
    send8(8'h00);
    v8 = 1'b0;
    drain();
    chk("det_count", 64'(det_n), 64'd3);
    chk("det_len", 64'(rec8_n), 64'd39);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/preamble_1010_tx.md
# preamble_1010_tx

Serial frame transmitter that is the sending end of the team's overlapping 1010 sequence-detector link. It takes parallel words through a valid/ready handshake. For each word it emits a serial frame on a single output bit: the 4-bit preamble 1010, then the payload MSB-first, then an optional even-parity bit. Frames go out back-to-back with no idle gap when the next word is already waiting. A downstream detector locks onto the preamble.

## Interface
- DATA_W, 8, payload width in bits; legal range 2..32
- PARITY_EN, 1, 1 appends an even-parity bit after the payload; 0 omits it
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a word to send
- in_data  input  DATA_W  payload word; sampled only on an accepted handshake
- in_ready  output  1  block can accept a word this cycle; combinational from state
- out  output  1  serial bit; registered
- out_valid  output  1  out carries a frame bit this cycle; registered
- frame_start  output  1  registered pulse, high during the first preamble bit of each frame

## Operation
- Frame length L = 4 + DATA_W + PARITY_EN bits, one bit per clk cycle.
- Bit order within a frame:
  - preamble 1,0,1,0
  - in_data[DATA_W-1] down to in_data[0]
  - parity = XOR of all payload bits, present when PARITY_EN=1
- Handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1. in_data is captured into an internal shift register on that edge. The block does not require in_valid or in_data to stay stable afterwards.
- in_ready is 1 in two cases:
  - state IDLE
  - state is driving the final bit of the current frame (last payload bit when PARITY_EN=0, else the parity bit)
- in_ready is 0 at every other point in a frame.
- States:
  - IDLE: out=0, out_valid=0. Go to PRE on accept.
  - PRE: 2-bit index 0..3 drives bits 1,0,1,0. Go to DATA after index 3.
  - DATA: bit counter of width clog2(DATA_W)+1; register shifts left each cycle. After DATA_W bits go to PAR if PARITY_EN=1, else to end-of-frame.
  - PAR: drives the parity bit for 1 cycle, then end-of-frame.
  - End-of-frame: go to PRE if a word was accepted on the final-bit edge, else IDLE.
- Parity is computed from the captured word, not from live in_data.
- The block does not escape the preamble pattern inside the payload. A false match on payload bits is a detector-side concern and is out of scope here.
- in_valid=1 with in_ready=0 is legal. The word waits with no loss and no duplication.

## Timing
- Reset (rstn=0, asynchronous):
  - state=IDLE
  - out=0, out_valid=0, frame_start=0
  - shift register and counters cleared
  - in_ready=1
- Reset mid-frame aborts the frame immediately. The remaining bits are never sent, and the next word after reset release starts a fresh frame.
- Latency: accept at edge k gives out_valid=1, out=1, frame_start=1 in the cycle after edge k. The final bit appears in the cycle after edge k+L-1.
- Back-to-back: if a word is accepted on the edge that ends the final bit, the next cycle is the first preamble bit. out_valid stays 1 continuously, and the sustained rate is 1 word per L cycles.
- Idle gap: with no accept at end-of-frame, out_valid=0 and out=0 from the next cycle until the cycle after the next accept.
- in_valid rising while in IDLE is accepted on that same edge. There is no extra bubble.
- frame_start is high for exactly one cycle per frame. It coincides with the first preamble bit.

## Test plan
- Reset release, then in_valid=1, in_data=0xA5, PARITY_EN=1, for 1 cycle -> the cycle after accept begins out = 1010 10100101 0 (13 cycles). out_valid=1 for exactly those 13 cycles, frame_start only on the first, and in_ready=0 except in IDLE and on the parity cycle.
- in_data=0x01 then 0x80 held back-to-back with in_valid=1, PARITY_EN=1 -> continuous 26-bit stream 1010 00000001 1 1010 10000000 1, with no gap and out_valid never dropping.
- PARITY_EN=0, DATA_W=4, in_data=0xF -> out = 1010 1111 (8 cycles), and in_ready=1 on the 8th bit.
- Assert rstn=0 during payload bit 3 of a 0xA5 frame, release, then send 0x3C -> outputs drop to 0 asynchronously, and the next frame is a clean 1010 00111100 0.
- Word presented while busy: in_data=0xFF asserted mid-frame and held until accepted -> it is accepted on the final-bit edge of the current frame and transmitted exactly once, immediately after.
- Loopback into the overlapping 1010 detector: a stream of 0x00 frames -> exactly one detection per frame, at the preamble's final 0.
